// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline controller.
//  - operand-forwarding select encodings driven onto the EX operand muxes
//  - pipeline stage index constants and redirect-resolution stage codes
//  - per-cycle control mode used by the controller's priority logic
package mips_pkg;

  localparam int DEF_REG_AW = 5;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  // Legal values of RESOLVE_STAGE
  localparam int RESOLVE_EX  = 1;
  localparam int RESOLVE_MEM = 2;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    CTL_NORMAL,
    CTL_FREEZE,
    CTL_REDIRECT,
    CTL_LOAD_USE
  } ctl_mode_e;

endpackage

// File: rtl/mips_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//  i_clk    in  clock
//  i_rst_n  in  async active-low reset (counter -> 0)
//  i_inc    in  count up by one this edge (holds at all-ones)
//  i_clr    in  zero on next edge; takes precedence over i_inc
//  o_cnt    out current count
module mips_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB, regs BF0..BF3).
// Resolves per cycle, in priority order: external freeze, branch/jump redirect,
// load-use stall, normal advance. Produces EX forwarding selects, ID write-through
// bypass, per-stage valid tracking and four saturating perf counters.
//  clk_CPU / rst_n_CPU           clock, async active-low reset
//  id_rs/id_rt, id_uses_rs/rt    sources of the ID instruction and whether read
//  ex_rs/ex_rt/ex_rd             sources / destination of the EX instruction
//  ex_regwrite, ex_memread       EX instruction writes a reg / is a load
//  mem_rd, mem_regwrite/memread  MEM destination, writes reg, is a load
//  wb_rd, wb_regwrite            WB destination, writes reg
//  redirect_req                  taken branch/jump in RESOLVE_STAGE
//  ext_stall_req                 freeze the whole pipe
//  cnt_clr                       synchronous clear of all perf counters
//  pc_en, bf0_en, pipe_en        PC / BF0 / BF1..BF3 load enables
//  bf0/1/2_flush                 register loads a NOP
//  fwd_a, fwd_b                  EX operand select (00 reg, 01 WB, 10 MEM)
//  id_byp_a, id_byp_b            ID takes WB data instead of register bank
//  cyc/ret/stall/flush_cnt       perf counters
module mips_pipe_ctrl
  import mips_pkg::*;
#(
  parameter int RESOLVE_STAGE = 2,
  parameter int REG_AW        = DEF_REG_AW,
  parameter int CNT_W         = 16
) (
  input  logic              clk_CPU,
  input  logic              rst_n_CPU,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic              wb_regwrite,
  input  logic              redirect_req,
  input  logic              ext_stall_req,
  input  logic              cnt_clr,
  output logic              pc_en,
  output logic              bf0_en,
  output logic              pipe_en,
  output logic              bf0_flush,
  output logic              bf1_flush,
  output logic              bf2_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              id_byp_a,
  output logic              id_byp_b,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  ret_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  if ((RESOLVE_STAGE != RESOLVE_EX) && (RESOLVE_STAGE != RESOLVE_MEM)) begin : g_bad_resolve
    $error("mips_pipe_ctrl: RESOLVE_STAGE must be 1 (EX) or 2 (MEM)");
  end

  localparam logic FLUSH_MEM_ON_REDIRECT = (RESOLVE_STAGE == RESOLVE_MEM);

  logic      r_v_id, r_v_ex, r_v_mem, r_v_wb;
  logic      w_load_use;
  ctl_mode_e w_mode;
  logic      w_mem_fwd_ok, w_wb_fwd_ok;
  fwd_sel_e  w_fwd_a, w_fwd_b;

  // Load in EX whose destination is read by the instruction sitting in ID
  assign w_load_use = r_v_ex & ex_memread & ex_regwrite & (ex_rd != '0) & r_v_id &
                      ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  always_comb begin
    w_mode = CTL_NORMAL;
    if (ext_stall_req)     w_mode = CTL_FREEZE;
    else if (redirect_req) w_mode = CTL_REDIRECT;
    else if (w_load_use)   w_mode = CTL_LOAD_USE;
  end

  always_comb begin
    pc_en     = 1'b1;
    bf0_en    = 1'b1;
    pipe_en   = 1'b1;
    bf0_flush = 1'b0;
    bf1_flush = 1'b0;
    bf2_flush = 1'b0;
    unique case (w_mode)
      CTL_FREEZE: begin
        pc_en   = 1'b0;
        bf0_en  = 1'b0;
        pipe_en = 1'b0;
      end
      CTL_REDIRECT: begin
        bf0_flush = 1'b1;
        bf1_flush = 1'b1;
        bf2_flush = FLUSH_MEM_ON_REDIRECT;
      end
      CTL_LOAD_USE: begin
        // Hold PC/BF0, inject a bubble into EX, let the load move on
        pc_en     = 1'b0;
        bf0_en    = 1'b0;
        bf1_flush = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n_CPU) begin
      pc_en     = 1'b0;
      bf0_en    = 1'b0;
      pipe_en   = 1'b0;
      bf0_flush = 1'b1;
      bf1_flush = 1'b1;
      bf2_flush = 1'b1;
    end
  end

  // Valid bits follow the instruction registers: flushed stages load 0,
  // a disabled BF0 keeps its (valid) stalled instruction.
  always_ff @(posedge clk_CPU or negedge rst_n_CPU) begin
    if (!rst_n_CPU) begin
      r_v_id  <= 1'b0;
      r_v_ex  <= 1'b0;
      r_v_mem <= 1'b0;
      r_v_wb  <= 1'b0;
    end else begin
      if (bf0_flush)   r_v_id <= 1'b0;
      else if (bf0_en) r_v_id <= 1'b1;
      if (pipe_en) begin
        r_v_ex  <= r_v_id & ~bf1_flush;
        r_v_mem <= r_v_ex & ~bf2_flush;
        r_v_wb  <= r_v_mem;
      end
    end
  end

  // A load in MEM has no data yet, so only non-load producers forward from MEM
  assign w_mem_fwd_ok = r_v_mem & mem_regwrite & ~mem_memread & (mem_rd != '0);
  assign w_wb_fwd_ok  = r_v_wb & wb_regwrite & (wb_rd != '0);

  always_comb begin
    w_fwd_a = FWD_REG;
    w_fwd_b = FWD_REG;
    if (w_mem_fwd_ok && (mem_rd == ex_rs))     w_fwd_a = FWD_MEM;
    else if (w_wb_fwd_ok && (wb_rd == ex_rs))  w_fwd_a = FWD_WB;
    if (w_mem_fwd_ok && (mem_rd == ex_rt))     w_fwd_b = FWD_MEM;
    else if (w_wb_fwd_ok && (wb_rd == ex_rt))  w_fwd_b = FWD_WB;
    if (!rst_n_CPU) begin
      w_fwd_a = FWD_REG;
      w_fwd_b = FWD_REG;
    end
  end

  assign fwd_a    = w_fwd_a;
  assign fwd_b    = w_fwd_b;
  assign id_byp_a = rst_n_CPU & w_wb_fwd_ok & (wb_rd == id_rs);
  assign id_byp_b = rst_n_CPU & w_wb_fwd_ok & (wb_rd == id_rt);

  mips_sat_cnt #(.CNT_W(CNT_W)) u_cyc_cnt (
    .i_clk(clk_CPU), .i_rst_n(rst_n_CPU), .i_inc(1'b1),
    .i_clr(cnt_clr), .o_cnt(cyc_cnt)
  );

  mips_sat_cnt #(.CNT_W(CNT_W)) u_ret_cnt (
    .i_clk(clk_CPU), .i_rst_n(rst_n_CPU), .i_inc(r_v_wb & pipe_en),
    .i_clr(cnt_clr), .o_cnt(ret_cnt)
  );

  mips_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk(clk_CPU), .i_rst_n(rst_n_CPU), .i_inc(w_mode == CTL_LOAD_USE),
    .i_clr(cnt_clr), .o_cnt(stall_cnt)
  );

  mips_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk(clk_CPU), .i_rst_n(rst_n_CPU), .i_inc(w_mode == CTL_REDIRECT),
    .i_clr(cnt_clr), .o_cnt(flush_cnt)
  );

endmodule
